ticket_change_dispenser: RTL and testbench

- Output-side partner of the ticket vending controller.
- Accepts one dispense order (change amount, ticket count) when a sale closes.
- Drives the coin hopper and the ticket printer one item at a time, over valid/ack handshakes.
- Breaks change into coins greedily, largest denomination first.
- Pulses done when the order is finished; pulses err when it rejects an order.

---
 rtl/ticket_change_dispenser.sv | 134 +++++++++++++
 tb/tb_ticket_change_dispenser.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ticket_change_dispenser.sv
// Coin/ticket dispenser: takes one order, then pays the change greedily (largest coin first) and prints tickets over valid/ack handshakes.
// Define TICKET_FIRST_EN to issue the tickets before the coins.
module ticket_change_dispenser #(
    parameter int unsigned COIN_A      = 50,
    parameter int unsigned COIN_B      = 10,
    parameter int unsigned COIN_C      = 5,
    parameter int unsigned COIN_D      = 1,
    parameter int unsigned MAX_TICKETS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] change_amt,
    input  logic [31:0] ticket_cnt,
    output logic        coin_valid,
    output logic [5:0]  coin_value,
    input  logic        coin_ack,
    output logic        ticket_valid,
    input  logic        ticket_ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] coins_issued
);

    typedef enum logic [1:0] {S_IDLE, S_COIN, S_TICKET, S_DONE} state_t;

    state_t      state_q, tgt_state_d;
    logic [31:0] rem_change_q, rem_tickets_q;
    logic [31:0] tgt_change_d, tgt_tickets_d;
    logic        req_ready_q, coin_valid_q, ticket_valid_q, busy_q, done_q, err_q;
    logic [5:0]  coin_value_q;
    logic [15:0] coins_issued_q;
    logic        accept_ok_d, step_d;

    function automatic logic [5:0] pick_coin(input logic [31:0] amt);
        if (amt >= COIN_A)      return 6'(COIN_A);
        else if (amt >= COIN_B) return 6'(COIN_B);
        else if (amt >= COIN_C) return 6'(COIN_C);
        else                    return 6'(COIN_D);
    endfunction

    // One routing rule serves accept, coin exhaustion and ticket exhaustion alike.
    function automatic state_t route(input logic [31:0] chg, input logic [31:0] tkt);
`ifdef TICKET_FIRST_EN
        if (tkt != 32'd0)      return S_TICKET;
        else if (chg != 32'd0) return S_COIN;
        else                   return S_DONE;
`else
        if (chg != 32'd0)      return S_COIN;
        else if (tkt != 32'd0) return S_TICKET;
        else                   return S_DONE;
`endif
    endfunction

    always_comb begin
        tgt_change_d  = change_amt;
        tgt_tickets_d = ticket_cnt;
        case (state_q)
            S_COIN:   tgt_change_d = rem_change_q - {26'd0, coin_value_q};
            S_TICKET: tgt_change_d = rem_change_q;
            default:  tgt_change_d = change_amt;
        endcase
        case (state_q)
            S_COIN:   tgt_tickets_d = rem_tickets_q;
            S_TICKET: tgt_tickets_d = rem_tickets_q - 32'd1;
            default:  tgt_tickets_d = ticket_cnt;
        endcase
        tgt_state_d = route(tgt_change_d, tgt_tickets_d);
        accept_ok_d = (state_q == S_IDLE) && req_valid && req_ready_q && (ticket_cnt <= MAX_TICKETS);
        step_d      = accept_ok_d
                    || ((state_q == S_COIN) && coin_ack)
                    || ((state_q == S_TICKET) && ticket_ack);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            rem_change_q   <= 32'd0;
            rem_tickets_q  <= 32'd0;
            req_ready_q    <= 1'b0;
            coin_valid_q   <= 1'b0;
            coin_value_q   <= 6'd0;
            ticket_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            coins_issued_q <= 16'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (step_d) begin
                state_q        <= tgt_state_d;
                rem_change_q   <= tgt_change_d;
                rem_tickets_q  <= tgt_tickets_d;
                req_ready_q    <= 1'b0;
                coin_valid_q   <= (tgt_state_d == S_COIN);
                coin_value_q   <= (tgt_state_d == S_COIN) ? pick_coin(tgt_change_d) : 6'd0;
                ticket_valid_q <= (tgt_state_d == S_TICKET);
                busy_q         <= (tgt_state_d == S_COIN) || (tgt_state_d == S_TICKET);
                done_q         <= (tgt_state_d == S_DONE);
                if (state_q == S_IDLE)
                    coins_issued_q <= 16'd0;
                else if ((state_q == S_COIN) && (coins_issued_q != 16'hFFFF))
                    coins_issued_q <= coins_issued_q + 16'd1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        req_ready_q <= 1'b1;
                        // Oversized ticket count: reject without touching the last order's state.
                        if (req_valid && req_ready_q && (ticket_cnt > MAX_TICKETS))
                            err_q <= 1'b1;
                    end
                    S_DONE: begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign req_ready    = req_ready_q;
    assign coin_valid   = coin_valid_q;
    assign coin_value   = coin_value_q;
    assign ticket_valid = ticket_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign coins_issued = coins_issued_q;

endmodule

// File: tb/tb_ticket_change_dispenser.sv
// Scoreboard bench for ticket_change_dispenser: a greedy change model queues expected events, a negedge monitor pops and compares them.
module tb_ticket_change_dispenser;

    localparam logic [1:0] K_COIN = 2'd0, K_TICKET = 2'd1, K_DONE = 2'd2, K_ERR = 2'd3;
    localparam int MAX_TKT = 16;
    localparam int LIMIT   = 4000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] change_amt;
    logic [31:0] ticket_cnt;
    logic        coin_valid;
    logic [5:0]  coin_value;
    logic        coin_ack;
    logic        ticket_valid;
    logic        ticket_ack;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] coins_issued;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  model_coins = 0;
    int  order_no = 0;
    bit  rand_acks = 1'b0;

    always #5 clk = ~clk;

    ticket_change_dispenser dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .change_amt   (change_amt),
        .ticket_cnt   (ticket_cnt),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .coin_ack     (coin_ack),
        .ticket_valid (ticket_valid),
        .ticket_ack   (ticket_ack),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .coins_issued (coins_issued)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: greedy change from the coin set, events listed in dispense order.
    task automatic model_order(input int amt, input int tkt);
        int coins[$];
        int r;
        if (tkt > MAX_TKT) begin
            exp_q.push_back('{K_ERR, 16'(model_coins)});
            return;
        end
        r = amt;
        while (r > 0) begin
            int c;
            if (r >= 50)      c = 50;
            else if (r >= 10) c = 10;
            else if (r >= 5)  c = 5;
            else              c = 1;
            coins.push_back(c);
            r -= c;
        end
`ifdef TICKET_FIRST_EN
        for (int i = 0; i < tkt; i++) exp_q.push_back('{K_TICKET, 16'd0});
        foreach (coins[i]) exp_q.push_back('{K_COIN, 16'(coins[i])});
`else
        foreach (coins[i]) exp_q.push_back('{K_COIN, 16'(coins[i])});
        for (int i = 0; i < tkt; i++) exp_q.push_back('{K_TICKET, 16'd0});
`endif
        exp_q.push_back('{K_DONE, 16'(coins.size())});
        model_coins = coins.size();
    endtask

    task automatic pop_check(input logic [1:0] kind, input logic [15:0] val);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event_kind", 32'(kind), 32'hFFFF);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", 32'(kind), 32'(e.kind));
        check("event_value", 32'(val), 32'(e.val));
    endtask

    // Monitor: samples on negedge, one event per completed handshake or pulse.
    initial begin
        logic       prev_wait = 1'b0;
        logic [5:0] prev_val  = 6'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_wait = 1'b0;
            end else begin
                if (prev_wait && coin_valid)
                    check("coin_value_stable", 32'(coin_value), 32'(prev_val));
                if (coin_valid && coin_ack)     pop_check(K_COIN, 16'(coin_value));
                if (ticket_valid && ticket_ack) pop_check(K_TICKET, 16'd0);
                if (done)                       pop_check(K_DONE, coins_issued);
                if (err)                        pop_check(K_ERR, coins_issued);
                if (coin_valid && ticket_valid)
                    check("both_valids", 32'd1, 32'd0);
                prev_wait = coin_valid && !coin_ack;
                prev_val  = coin_value;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_acks) begin
                coin_ack   = ($urandom_range(0, 9) < 7);
                ticket_ack = ($urandom_range(0, 9) < 7);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send_order(input int amt, input int tkt);
        int n = 0;
        while (!req_ready && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_timeout", 32'(n < LIMIT), 32'd1);
        order_no++;
        $display("order %0d: change=%0d tickets=%0d", order_no, amt, tkt);
        model_order(amt, tkt);
        change_amt = 32'(amt);
        ticket_cnt = 32'(tkt);
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(req_ready && exp_q.size() == 0) && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 32'(n < LIMIT), 32'd1);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; change_amt = '0; ticket_cnt = '0;
        coin_ack = 1'b0; ticket_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_valids", {30'd0, coin_valid, ticket_valid}, 32'd0);
        check("rst_pulses", {29'd0, busy, done, err}, 32'd0);
        check("rst_coins", 32'(coins_issued), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic order with acks held high: strictly consecutive dispensing.
        coin_ack = 1'b1; ticket_ack = 1'b1;
        send_order(67, 2);
        for (int i = 0; i < 7; i++) begin
            bit want_coin;
`ifdef TICKET_FIRST_EN
            want_coin = (i >= 2);
`else
            want_coin = (i < 5);
`endif
            @(negedge clk);
            check("basic_coin_valid", 32'(coin_valid), 32'(want_coin));
            check("basic_ticket_valid", 32'(ticket_valid), 32'(!want_coin));
        end
        @(negedge clk);
        check("basic_done", 32'(done), 32'd1);
        check("basic_coins_issued", 32'(coins_issued), 32'd5);
        @(negedge clk);
        check("basic_ready_back", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        wait_idle();

        // Back-pressure: coin held for 6 cycles, acked on the last one.
        coin_ack = 1'b0;
        send_order(10, 0);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) coin_ack = 1'b1;
            @(negedge clk);
            check("bp_coin_valid", 32'(coin_valid), 32'd1);
            check("bp_coin_value", 32'(coin_value), 32'd10);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("bp_done", 32'(done), 32'd1);
        check("bp_coins_issued", 32'(coins_issued), 32'd1);
        @(posedge clk);
        #1;
        wait_idle();

        // Rejected order.
        send_order(5, 17);
        @(negedge clk);
        check("rej_err", 32'(err), 32'd1);
        check("rej_ready", 32'(req_ready), 32'd1);
        check("rej_valids", {30'd0, coin_valid, ticket_valid}, 32'd0);
        @(negedge clk);
        check("rej_err_once", 32'(err), 32'd0);
        check("rej_valids_after", {30'd0, coin_valid, ticket_valid}, 32'd0);
        @(posedge clk);
        #1;
        wait_idle();

        // Max tickets, no change.
        rand_acks = 1'b1;
        send_order(0, 16);
        wait_idle();
        rand_acks = 1'b0;

        // Zero order.
        send_order(0, 0);
        @(negedge clk);
        check("zero_done", 32'(done), 32'd1);
        check("zero_valids", {30'd0, coin_valid, ticket_valid}, 32'd0);
        @(posedge clk);
        #1;
        wait_idle();

        // Reset during the second coin of a change-30 order.
        coin_ack = 1'b1;
        send_order(30, 0);
        @(posedge clk);
        #1;
        check("mid_second_coin", 32'(coin_valid), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        model_coins = 0;
        @(posedge clk);
        #1;
        check("mid_rst_valids", {30'd0, coin_valid, ticket_valid}, 32'd0);
        check("mid_rst_flags", {28'd0, req_ready, busy, done, err}, 32'd0);
        check("mid_rst_coins", {10'd0, coin_value, coins_issued}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mid_no_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1;
        send_order(5, 0);
        wait_idle();

        // Mixed order, exercises the build's coin/ticket ordering.
        rand_acks = 1'b1;
        send_order(6, 1);
        wait_idle();

        // Random orders; some with a stray request while busy.
        for (int k = 0; k < 30; k++) begin
            int amt, tkt;
            amt = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 260));
            tkt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(17, 40)) : int'($urandom_range(0, 6));
            send_order(amt, tkt);
            if (busy && $urandom_range(0, 1) == 1) begin
                change_amt = 32'd3; ticket_cnt = 32'd1;
                req_valid = 1'b1;
                @(posedge clk);
                #1;
                req_valid = 1'b0;
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();
        rand_acks = 1'b0;
        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
